// File: rtl/dn_iter_refresh_ctrl_pkg.sv
// Shared types and defaults for the decision-node IB-RAM refresh controller.
package dn_iter_refresh_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_DN_LOAD_CYCLE  = 64;
  localparam int DEF_ITER_ROM_GROUP = 25;
  localparam int DEF_MAX_ITER       = 50;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_fn(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dn_iter_refresh_ctrl_if.sv
// Request/status bundle between the iteration update control unit and the DN refresh controller.
interface dn_iter_refresh_ctrl_if #(
  parameter int ROM_ADDR_BW  = 11,
  parameter int PAGE_ADDR_BW = 6,
  parameter int ITER_ADDR_BW = 6
);
  logic                    refresh_req;
  logic                    abort;
  logic                    busy;
  logic                    refresh_done;
  logic                    all_done;
  logic [ITER_ADDR_BW-1:0] iter_cnt;
  logic                    iter_switch;
  logic                    latch_rstn;
  logic [ROM_ADDR_BW-1:0]  latch_iter_base;
  logic                    ram_we;
  logic [PAGE_ADDR_BW-1:0] ram_waddr;

  modport master (
    output refresh_req, abort,
    input  busy, refresh_done, all_done, iter_cnt, iter_switch,
           latch_rstn, latch_iter_base, ram_we, ram_waddr
  );

  modport slave (
    input  refresh_req, abort,
    output busy, refresh_done, all_done, iter_cnt, iter_switch,
           latch_rstn, latch_iter_base, ram_we, ram_waddr
  );
endinterface

// File: rtl/dn_iter_refresh_ctrl_page_cnt.sv
// IB-RAM page-address up-counter with enable, synchronous clear and terminal-count flag.
module dn_iter_refresh_ctrl_page_cnt #(
  parameter int PAGE_ADDR_BW  = 6,
  parameter int DN_LOAD_CYCLE = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  output logic [PAGE_ADDR_BW-1:0] cnt,
  output logic                    tc
);
  localparam logic [PAGE_ADDR_BW-1:0] TC_VAL  = PAGE_ADDR_BW'(DN_LOAD_CYCLE - 1);
  localparam logic [PAGE_ADDR_BW-1:0] CNT_ONE = PAGE_ADDR_BW'(1);

  logic [PAGE_ADDR_BW-1:0] cnt_q;
  logic [PAGE_ADDR_BW-1:0] cnt_d;

  // Next count: clear dominates enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);
endmodule

// File: rtl/dn_iter_refresh_ctrl.sv
// Sequences one DN IB-RAM refresh per iteration: latch load, ROM prime, page writes, completion.
module dn_iter_refresh_ctrl
  import dn_iter_refresh_ctrl_pkg::*;
#(
  parameter int ROM_ADDR_BW    = 11,
  parameter int PAGE_ADDR_BW   = 6,
  parameter int ITER_ADDR_BW   = 6,
  parameter int DN_LOAD_CYCLE  = DEF_DN_LOAD_CYCLE,
  parameter int ITER_ROM_GROUP = DEF_ITER_ROM_GROUP,
  parameter int MAX_ITER       = DEF_MAX_ITER,
  parameter int ROM_LATENCY    = 1
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  dn_iter_refresh_ctrl_if.slave bus
);
  localparam int                      PRIME_BW   = clog2_fn(ROM_LATENCY + 1);
  localparam logic [PRIME_BW-1:0]     PRIME_LAST = PRIME_BW'(ROM_LATENCY);
  localparam logic [PRIME_BW-1:0]     PRIME_ONE  = PRIME_BW'(1);
  localparam logic [ITER_ADDR_BW-1:0] ITER_ONE   = ITER_ADDR_BW'(1);
  localparam logic [ITER_ADDR_BW-1:0] GROUP_C    = ITER_ADDR_BW'(ITER_ROM_GROUP);
  localparam logic [ITER_ADDR_BW-1:0] MAX_C      = ITER_ADDR_BW'(MAX_ITER);
  localparam logic [31:0]             LOAD_U     = 32'(DN_LOAD_CYCLE);

  state_e                  state_q, state_d;
  logic [PRIME_BW-1:0]     prime_cnt_q, prime_cnt_d;
  logic [ITER_ADDR_BW-1:0] iter_cnt_q, iter_cnt_d;
  logic                    iter_switch_q, iter_switch_d;
  logic                    all_done_q, all_done_d;
  logic [ROM_ADDR_BW-1:0]  base_q, base_d;
  logic                    busy_q, busy_d;
  logic                    refresh_done_q, refresh_done_d;
  logic                    latch_rstn_q, latch_rstn_d;
  logic                    ram_we_q, ram_we_d;

  logic [ITER_ADDR_BW-1:0] grp_idx_s;
  logic [ITER_ADDR_BW-1:0] iter_inc_s;
  logic [ROM_ADDR_BW-1:0]  base_s;
  logic                    page_en_s;
  logic                    page_clr_s;
  logic                    page_tc_s;
  logic [PAGE_ADDR_BW-1:0] page_cnt_s;

  // Iteration index within its ROM group selects the base row.
  assign grp_idx_s  = (iter_cnt_q >= GROUP_C) ? (iter_cnt_q - GROUP_C) : iter_cnt_q;
  assign base_s     = ROM_ADDR_BW'(32'(grp_idx_s) * LOAD_U);
  assign iter_inc_s = iter_cnt_q + ITER_ONE;
  assign page_en_s  = (state_q == ST_WRITE);
  assign page_clr_s = bus.abort || ((state_q == ST_WRITE) && page_tc_s);

  dn_iter_refresh_ctrl_page_cnt #(
    .PAGE_ADDR_BW  (PAGE_ADDR_BW),
    .DN_LOAD_CYCLE (DN_LOAD_CYCLE)
  ) u_page_cnt (
    .clk  (write_clk),
    .rstn (rstn),
    .en   (page_en_s),
    .clr  (page_clr_s),
    .cnt  (page_cnt_s),
    .tc   (page_tc_s)
  );

  // Next state and next registered outputs; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    prime_cnt_d   = prime_cnt_q;
    iter_cnt_d    = iter_cnt_q;
    iter_switch_d = iter_switch_q;
    all_done_d    = all_done_q;
    base_d        = base_q;
    if (bus.abort) begin
      state_d       = ST_IDLE;
      iter_cnt_d    = '0;
      iter_switch_d = 1'b0;
      all_done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.refresh_req && !all_done_q) begin
            state_d = ST_LOAD;
            base_d  = base_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_d     = ST_PRIME;
          prime_cnt_d = '0;
        end
        ST_PRIME: begin
          if (prime_cnt_q == PRIME_LAST) begin
            state_d = ST_WRITE;
          end else begin
            prime_cnt_d = prime_cnt_q + PRIME_ONE;
          end
        end
        ST_WRITE: begin
          if (page_tc_s) begin
            state_d       = ST_DONE;
            iter_cnt_d    = iter_inc_s;
            iter_switch_d = (iter_inc_s >= GROUP_C);
            all_done_d    = (iter_inc_s == MAX_C);
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d         = (state_d != ST_IDLE);
    latch_rstn_d   = (state_d != ST_LOAD);
    ram_we_d       = (state_d == ST_WRITE);
    refresh_done_d = (state_d == ST_DONE);
  end

  // FSM state and all registered outputs.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      prime_cnt_q    <= '0;
      iter_cnt_q     <= '0;
      iter_switch_q  <= 1'b0;
      all_done_q     <= 1'b0;
      base_q         <= '0;
      busy_q         <= 1'b0;
      refresh_done_q <= 1'b0;
      latch_rstn_q   <= 1'b1;
      ram_we_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      prime_cnt_q    <= prime_cnt_d;
      iter_cnt_q     <= iter_cnt_d;
      iter_switch_q  <= iter_switch_d;
      all_done_q     <= all_done_d;
      base_q         <= base_d;
      busy_q         <= busy_d;
      refresh_done_q <= refresh_done_d;
      latch_rstn_q   <= latch_rstn_d;
      ram_we_q       <= ram_we_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.refresh_done    = refresh_done_q;
  assign bus.all_done        = all_done_q;
  assign bus.iter_cnt        = iter_cnt_q;
  assign bus.iter_switch     = iter_switch_q;
  assign bus.latch_rstn      = latch_rstn_q;
  assign bus.latch_iter_base = base_q;
  assign bus.ram_we          = ram_we_q;
  assign bus.ram_waddr       = page_cnt_s;
endmodule

// File: tb/tb_dn_iter_refresh_ctrl.sv
// Randomised bench for dn_iter_refresh_ctrl against a cycle-phase reference model.
module tb_dn_iter_refresh_ctrl;
  localparam int ROM_ADDR_BW    = 11;
  localparam int PAGE_ADDR_BW   = 6;
  localparam int ITER_ADDR_BW   = 6;
  localparam int DN_LOAD_CYCLE  = 64;
  localparam int ITER_ROM_GROUP = 25;
  localparam int MAX_ITER       = 50;
  localparam int ROM_LATENCY    = 1;
  localparam int REF_LEN        = ROM_LATENCY + DN_LOAD_CYCLE + 3;
  localparam int VW             = 3 + PAGE_ADDR_BW + 1 + ITER_ADDR_BW + 2 + ROM_ADDR_BW;

  logic write_clk = 1'b0;
  logic rstn      = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   model_iter = 0;
  int   model_base = 0;

  dn_iter_refresh_ctrl_if #(
    .ROM_ADDR_BW(ROM_ADDR_BW), .PAGE_ADDR_BW(PAGE_ADDR_BW), .ITER_ADDR_BW(ITER_ADDR_BW)
  ) bus ();

  dn_iter_refresh_ctrl #(
    .ROM_ADDR_BW(ROM_ADDR_BW), .PAGE_ADDR_BW(PAGE_ADDR_BW), .ITER_ADDR_BW(ITER_ADDR_BW),
    .DN_LOAD_CYCLE(DN_LOAD_CYCLE), .ITER_ROM_GROUP(ITER_ROM_GROUP),
    .MAX_ITER(MAX_ITER), .ROM_LATENCY(ROM_LATENCY)
  ) dut (
    .write_clk (write_clk),
    .rstn      (rstn),
    .bus       (bus)
  );

  always #5 write_clk = ~write_clk;

  function automatic logic [VW-1:0] obs();
    return {bus.busy, bus.latch_rstn, bus.ram_we, bus.ram_waddr, bus.refresh_done,
            bus.iter_cnt, bus.iter_switch, bus.all_done, bus.latch_iter_base};
  endfunction

  // Idle picture after k completed refreshes with the given last base.
  function automatic logic [VW-1:0] exp_idle(input int k, input int base);
    return {1'b0, 1'b1, 1'b0, PAGE_ADDR_BW'(0), 1'b0, ITER_ADDR_BW'(k),
            (k >= ITER_ROM_GROUP), (k == MAX_ITER), ROM_ADDR_BW'(base)};
  endfunction

  // Expected outputs p cycles into a refresh that started with k completed iterations.
  function automatic logic [VW-1:0] exp_refresh(input int p, input int k);
    int  w0, wend, dp, it;
    logic we;
    w0   = ROM_LATENCY + 2;
    wend = w0 + DN_LOAD_CYCLE - 1;
    dp   = wend + 1;
    it   = (p >= dp) ? k + 1 : k;
    we   = (p >= w0) && (p <= wend);
    return {(p <= dp), (p != 0), we, PAGE_ADDR_BW'(we ? p - w0 : 0), (p == dp),
            ITER_ADDR_BW'(it), (it >= ITER_ROM_GROUP), (it == MAX_ITER),
            ROM_ADDR_BW'((k % ITER_ROM_GROUP) * DN_LOAD_CYCLE)};
  endfunction

  // One refresh from IDLE; optional extra request, abort or reset at phase p.
  task automatic run_refresh(input string name, input int req_at, input int abort_at,
                             input int rst_at, input bit rand_req);
    logic [VW-1:0] act_v, exp_v;
    model_base = (model_iter % ITER_ROM_GROUP) * DN_LOAD_CYCLE;
    bus.refresh_req = 1'b1;
    for (int p = 0; p <= REF_LEN; p++) begin
      @(negedge write_clk);
      bus.refresh_req = 1'b0;
      act_v = obs();
      exp_v = exp_refresh(p, model_iter);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL %s iter=%0d p=%0d got=%h want=%h", name, model_iter, p, act_v, exp_v);
      else n_pass++;
      if (p == abort_at) begin
        bus.abort = 1'b1;
        @(negedge write_clk);
        bus.abort = 1'b0;
        act_v = obs();
        exp_v = exp_idle(0, model_base);
        n_checks++;
        if (act_v[VW-1:ROM_ADDR_BW] !== exp_v[VW-1:ROM_ADDR_BW])
          $display("FAIL %s_abort got=%h want=%h", name, act_v[VW-1:ROM_ADDR_BW], exp_v[VW-1:ROM_ADDR_BW]);
        else n_pass++;
        model_iter = 0;
        return;
      end
      if (p == rst_at) begin
        #2 rstn = 1'b0;
        #1;
        act_v = obs();
        exp_v = exp_idle(0, 0);
        n_checks++;
        if (act_v !== exp_v) $display("FAIL %s_async_rst got=%h want=%h", name, act_v, exp_v);
        else n_pass++;
        @(negedge write_clk);
        rstn = 1'b1;
        model_iter = 0;
        model_base = 0;
        return;
      end
      if ((p < REF_LEN) && ((p == req_at) || (rand_req && ($urandom_range(0, 3) == 0))))
        bus.refresh_req = 1'b1;
    end
    model_iter++;
  endtask

  task automatic check_idle(input string name, input int ncyc);
    logic [VW-1:0] act_v, exp_v;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge write_clk);
      act_v = obs();
      exp_v = exp_idle(model_iter, model_base);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL %s cyc=%0d got=%h want=%h", name, i, act_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] act_v, exp_v;
    exp_v = exp_idle(0, 0);
    repeat (3) @(negedge write_clk);
    act_v = obs();
    n_checks++;
    if (act_v !== exp_v) $display("FAIL reset_held got=%h want=%h", act_v, exp_v);
    else n_pass++;
    rstn = 1'b1;
    @(negedge write_clk);
    act_v = obs();
    n_checks++;
    if (act_v !== exp_v) $display("FAIL reset_release got=%h want=%h", act_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_single_refresh();
    run_refresh("single", -1, -1, -1, 1'b0);
    check_idle("single_idle", 2);
  endtask

  task automatic test_req_during_write();
    run_refresh("req_in_write", ROM_LATENCY + 2 + 10, -1, -1, 1'b0);
    check_idle("req_in_write_idle", 4);
  endtask

  task automatic test_abort();
    run_refresh("abort", -1, ROM_LATENCY + 2 + 30, -1, 1'b0);
    check_idle("abort_idle", 3);
  endtask

  task automatic test_groups();
    for (int i = 0; i < MAX_ITER; i++) begin
      run_refresh("groups", -1, -1, -1, 1'b1);
      if (i == ITER_ROM_GROUP - 1) begin
        n_checks++;
        if ({bus.iter_switch, bus.iter_cnt} !== {1'b1, ITER_ADDR_BW'(ITER_ROM_GROUP)})
          $display("FAIL group_wrap sw=%b iter=%0d want sw=1 iter=%0d", bus.iter_switch, bus.iter_cnt, ITER_ROM_GROUP);
        else n_pass++;
      end
      if ($urandom_range(0, 1) == 1) check_idle("groups_gap", $urandom_range(1, 3));
    end
  endtask

  task automatic test_all_done_ignore();
    logic [VW-1:0] act_v, exp_v;
    bus.refresh_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge write_clk);
      bus.refresh_req = 1'b0;
      act_v = obs();
      exp_v = exp_idle(MAX_ITER, model_base);
      n_checks++;
      if (act_v !== exp_v) $display("FAIL all_done_ignore cyc=%0d got=%h want=%h", i, act_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] act_v, exp_v;
    bus.abort = 1'b1;
    bus.refresh_req = 1'b1;
    @(negedge write_clk);
    bus.abort = 1'b0;
    bus.refresh_req = 1'b0;
    act_v = obs();
    exp_v = exp_idle(0, 0);
    n_checks++;
    if (act_v[VW-1:ROM_ADDR_BW] !== exp_v[VW-1:ROM_ADDR_BW])
      $display("FAIL abort_with_req got=%h want=%h", act_v[VW-1:ROM_ADDR_BW], exp_v[VW-1:ROM_ADDR_BW]);
    else n_pass++;
    model_iter = 0;
    for (int i = 0; i < 26; i++) run_refresh("to_iter27", -1, -1, -1, 1'b0);
    run_refresh("rst_mid", -1, -1, ROM_LATENCY + 2 + 5, 1'b0);
    check_idle("after_rst_idle", 1);
    run_refresh("after_rst", -1, -1, -1, 1'b1);
  endtask

  initial begin
    bus.refresh_req = 1'b0;
    bus.abort       = 1'b0;
    test_reset();
    test_single_refresh();
    test_req_during_write();
    test_abort();
    test_groups();
    test_all_done_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
